// File: rtl/out_port_tx.sv
// rtl/out_port_tx.sv - picorv32 bus-mapped byte FIFO driving the out_dat/out_ctl toggle protocol
module out_port_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 16,
    parameter int          GAP       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  out_dat,
    output logic        out_ctl
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      fifo [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic        hit;
    logic        is_status;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        ack;
    logic [31:0] rdata_next;

    assign hit       = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]) && !mem_ready;
    assign is_status = mem_addr[2];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop       = (state == IDLE) && !empty;
    assign push_req  = hit && !is_status && mem_wstrb[0];
    // A full FIFO still accepts the byte in the cycle the transmitter frees a slot.
    assign push      = push_req && (!full || pop);
    assign ack       = hit && (!push_req || push);

    always_comb begin
        rdata_next = 32'h0;
        if (is_status && (mem_wstrb == 4'h0)) begin
            rdata_next = {16'h0, 8'(count), 6'h0, empty, full};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            gap_cnt   <= '0;
            out_dat   <= 8'h0;
            out_ctl   <= 1'b0;
        end else begin
            mem_ready <= ack;
            mem_rdata <= ack ? rdata_next : 32'h0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        out_dat <= fifo[rd_ptr];
                        out_ctl <= ~out_ctl;
                        gap_cnt <= GW'(GAP - 1);
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
